// File: rtl/knns_drain_seq.sv
`default_nettype none
// ============================================================================
// Module   : knns_drain_seq
// Brief    : Runs one K-nearest-neighbour search pass, snapshots the sorted
//            list and streams it nearest-first while summing coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module knns_drain_seq #(
  parameter  int W  = 32,
  parameter  int K  = 10,
  parameter  int N  = 64,
  localparam int SW = W + $clog2(K + 1),
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pt_valid,
  input  logic [2*W*K-1:0]   knn_list,
  output logic               knn_clr,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_x,
  output logic [W-1:0]       out_y,
  output logic [IW-1:0]      out_idx,
  output logic [SW-1:0]      sum_x,
  output logic [SW-1:0]      sum_y,
  output logic               done
);

  localparam int c_M  = (N < K) ? N : K;
  localparam int c_CW = $clog2(N + 1);
  localparam logic [c_CW-1:0] c_N_LAST = c_CW'(N - 1);
  localparam logic [IW-1:0]   c_M_LAST = IW'(c_M - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SCAN    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_CW-1:0]          r_cnt;
  logic [IW-1:0]            r_rank;
  logic [K-1:0][2*W-1:0]    r_snap;
  logic [SW-1:0]            r_sum_x;
  logic [SW-1:0]            r_sum_y;
  logic                     r_done;
  logic [2*W-1:0]           w_entry;
  logic                     w_last;

  assign w_entry = r_snap[r_rank];
  assign w_last  = (r_rank == c_M_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_CLEAR;
      S_CLEAR:   w_state_next = S_SCAN;
      S_SCAN:    if (pt_valid && (r_cnt == c_N_LAST)) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_DRAIN;
      S_DRAIN:   if (out_ready && w_last) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rank  <= '0;
      r_snap  <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_cnt   <= '0;
          r_sum_x <= '0;
          r_sum_y <= '0;
        end
        S_SCAN: begin
          if (pt_valid) r_cnt <= r_cnt + 1'b1;
        end
        S_CAPTURE: begin
          // The search stage settled on the previous edge, so this is the final list.
          r_snap <= knn_list;
          r_rank <= '0;
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_sum_x <= r_sum_x + {{(SW-W){1'b0}}, w_entry[2*W-1:W]};
            r_sum_y <= r_sum_y + {{(SW-W){1'b0}}, w_entry[W-1:0]};
            if (w_last) r_done <= 1'b1;
            else        r_rank <= r_rank + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign knn_clr   = (r_state == S_CLEAR);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DRAIN);
  assign out_x     = w_entry[2*W-1:W];
  assign out_y     = w_entry[W-1:0];
  assign out_idx   = r_rank;
  assign sum_x     = r_sum_x;
  assign sum_y     = r_sum_y;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_knns_drain_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_knns_drain_seq
// Brief    : Directed self-checking bench for knns_drain_seq (W=8, K=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_knns_drain_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: N=6, instance B: N=2 (fewer points than list slots)
  logic        start_a, pt_valid_a, out_ready_a, knn_clr_a, busy_a, out_valid_a, done_a;
  logic [7:0]  px_a, py_a, out_x_a, out_y_a;
  logic [1:0]  out_idx_a;
  logic [10:0] sum_x_a, sum_y_a;
  logic [63:0] list_a;
  logic [67:0] mdl_a;

  logic        start_b, pt_valid_b, out_ready_b, knn_clr_b, busy_b, out_valid_b, done_b;
  logic [7:0]  px_b, py_b, out_x_b, out_y_b;
  logic [1:0]  out_idx_b;
  logic [10:0] sum_x_b, sum_y_b;
  logic [63:0] list_b;
  logic [67:0] mdl_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] pts_x [6] = '{8'd5, 8'd1, 8'd3, 8'd0, 8'd9, 8'd2};
  logic [7:0] pts_y [6] = '{8'd5, 8'd0, 8'd3, 8'd2, 8'd9, 8'd2};
  logic [7:0] ex    [4] = '{8'd1, 8'd0, 8'd2, 8'd3};
  logic [7:0] ey    [4] = '{8'd0, 8'd2, 8'd2, 8'd3};

  knns_drain_seq #(.W(8), .K(4), .N(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pt_valid(pt_valid_a), .knn_list(list_a),
    .knn_clr(knn_clr_a), .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_x(out_x_a), .out_y(out_y_a), .out_idx(out_idx_a),
    .sum_x(sum_x_a), .sum_y(sum_y_a), .done(done_a)
  );

  knns_drain_seq #(.W(8), .K(4), .N(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pt_valid(pt_valid_b), .knn_list(list_b),
    .knn_clr(knn_clr_b), .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_x(out_x_b), .out_y(out_y_b), .out_idx(out_idx_b),
    .sum_x(sum_x_b), .sum_y(sum_y_b), .done(done_b)
  );

  // Search-stage stand-in: sorted insert by squared distance from (0,0); entry = {valid, x, y}
  function automatic logic [67:0] ins(input logic [67:0] l, input logic [7:0] x, input logic [7:0] y);
    logic [67:0] r;
    logic [16:0] e;
    int p, d, ed;
    r = l;
    p = 4;
    d = int'(x) * int'(x) + int'(y) * int'(y);
    for (int i = 3; i >= 0; i--) begin
      e  = l[i*17 +: 17];
      ed = int'(e[15:8]) * int'(e[15:8]) + int'(e[7:0]) * int'(e[7:0]);
      if (!e[16] || ed > d) p = i;
    end
    if (p < 4) begin
      for (int i = 3; i > p; i--) r[i*17 +: 17] = l[(i-1)*17 +: 17];
      r[p*17 +: 17] = {1'b1, x, y};
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || knn_clr_a) mdl_a <= '0;
    else if (pt_valid_a)  mdl_a <= ins(mdl_a, px_a, py_a);
  end

  always @(posedge clk or posedge rst) begin
    if (rst || knn_clr_b) mdl_b <= '0;
    else if (pt_valid_b)  mdl_b <= ins(mdl_b, px_b, py_b);
  end

  always_comb begin
    list_a = '0;
    list_b = '0;
    for (int i = 0; i < 4; i++) begin
      list_a[i*16 +: 16] = mdl_a[i*17 +: 16];
      list_b[i*16 +: 16] = mdl_b[i*17 +: 16];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_knn_clr"},   knn_clr_a,   0);
    chk({tag, "_busy"},      busy_a,      0);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_out_x"},     out_x_a,     0);
    chk({tag, "_out_y"},     out_y_a,     0);
    chk({tag, "_out_idx"},   out_idx_a,   0);
    chk({tag, "_sum_x"},     sum_x_a,     0);
    chk({tag, "_sum_y"},     sum_y_a,     0);
    chk({tag, "_done"},      done_a,      0);
  endtask

  // Called at a falling edge while A is idle; returns at the first SCAN cycle.
  task automatic do_start(input logic [10:0] psx, input logic [10:0] psy);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("clear_pulse",       knn_clr_a, 1);
    chk("clear_busy",        busy_a,    1);
    chk("clear_prior_sum_x", sum_x_a,   psx);
    chk("clear_prior_sum_y", sum_y_a,   psy);
    @(negedge clk);
    chk("scan_clr_low",      knn_clr_a, 0);
    chk("scan_sum_x_zero",   sum_x_a,   0);
    chk("scan_sum_y_zero",   sum_y_a,   0);
  endtask

  // Feeds the six points with 'gap' idle cycles before each; returns at the first DRAIN cycle.
  task automatic feed(input int gap);
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < gap; g++) begin
        start_a    = (g == 0);
        pt_valid_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        chk("scan_no_valid", out_valid_a, 0);
        chk("scan_busy",     busy_a,      1);
        chk("scan_no_clr",   knn_clr_a,   0);
      end
      pt_valid_a = 1'b1;
      px_a       = pts_x[i];
      py_a       = pts_y[i];
      @(negedge clk);
      pt_valid_a = 1'b0;
    end
    chk("capture_no_valid", out_valid_a, 0);
    chk("capture_busy",     busy_a,      1);
    @(negedge clk);
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,..., 2: ready always plus start/pt_valid noise
  task automatic drain(input int m, input int mode, input bit full);
    int k, c;
    logic [10:0] psx, psy;
    bit rdy;
    k = 0; c = 0; psx = '0; psy = '0;
    while (k < m && c < 40) begin
      rdy = (mode == 1) ? (c % 3 == 0) : 1'b1;
      out_ready_a = rdy;
      if (mode == 2 && c == 1) begin
        start_a = 1'b1; pt_valid_a = 1'b1; px_a = 8'd0; py_a = 8'd0;
      end else begin
        start_a = 1'b0; pt_valid_a = 1'b0;
      end
      chk("drain_valid", out_valid_a, 1);
      chk("drain_idx",   out_idx_a,   k);
      chk("drain_x",     out_x_a,     ex[k]);
      chk("drain_y",     out_y_a,     ey[k]);
      chk("drain_sum_x", sum_x_a,     psx);
      chk("drain_sum_y", sum_y_a,     psy);
      chk("drain_done",  done_a,      0);
      chk("drain_clr",   knn_clr_a,   0);
      @(negedge clk);
      if (rdy) begin
        psx = psx + ex[k];
        psy = psy + ey[k];
        k++;
      end
      c++;
    end
    out_ready_a = 1'b0; start_a = 1'b0; pt_valid_a = 1'b0;
    chk("drain_count", k, m);
    if (full) begin
      chk("end_done",      done_a,      1);
      chk("end_busy",      busy_a,      0);
      chk("end_out_valid", out_valid_a, 0);
      chk("end_sum_x",     sum_x_a,     6);
      chk("end_sum_y",     sum_y_a,     7);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 0; pt_valid_a = 0; out_ready_a = 0; px_a = 0; py_a = 0;
    start_b = 0; pt_valid_b = 0; out_ready_b = 0; px_b = 0; py_b = 0;
    repeat (2) @(negedge clk);
    chk_reset_a("reset");
    chk("reset_b_busy", busy_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous points, always ready
    do_start(11'd0, 11'd0);
    feed(0);
    drain(4, 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done_a,  0);
    chk("sum_x_held",     sum_x_a, 6);
    chk("sum_y_held",     sum_y_a, 7);

    // Back-pressure pattern
    @(negedge clk);
    do_start(11'd6, 11'd7);
    feed(0);
    drain(4, 1, 1);

    // Sparse points, start pulses in SCAN/DRAIN, list disturbed after capture
    @(negedge clk);
    do_start(11'd6, 11'd7);
    feed(2);
    drain(4, 2, 1);

    // Back-to-back start in the cycle busy falls
    do_start(11'd6, 11'd7);
    feed(0);
    drain(4, 0, 1);

    // Reset mid-drain after two handshakes, then a clean search
    @(negedge clk);
    do_start(11'd6, 11'd7);
    feed(0);
    drain(2, 0, 0);
    rst = 1'b1;
    #1;
    chk_reset_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(11'd0, 11'd0);
    feed(0);
    drain(4, 0, 1);

    // N=2 < K=4: only two entries emitted
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_clear_pulse", knn_clr_b, 1);
    @(negedge clk);
    pt_valid_b = 1'b1; px_b = 8'd4; py_b = 8'd1;
    @(negedge clk);
    px_b = 8'd2; py_b = 8'd6;
    @(negedge clk);
    pt_valid_b = 1'b0;
    chk("b_capture_no_valid", out_valid_b, 0);
    chk("b_capture_busy",     busy_b,      1);
    out_ready_b = 1'b1;
    @(negedge clk);
    chk("b_e0_valid", out_valid_b, 1);
    chk("b_e0_idx",   out_idx_b,   0);
    chk("b_e0_x",     out_x_b,     4);
    chk("b_e0_y",     out_y_b,     1);
    @(negedge clk);
    chk("b_e1_valid", out_valid_b, 1);
    chk("b_e1_idx",   out_idx_b,   1);
    chk("b_e1_x",     out_x_b,     2);
    chk("b_e1_y",     out_y_b,     6);
    chk("b_e1_sum_x", sum_x_b,     4);
    @(negedge clk);
    chk("b_done",      done_b,      1);
    chk("b_end_valid", out_valid_b, 0);
    chk("b_end_busy",  busy_b,      0);
    chk("b_sum_x",     sum_x_b,     6);
    chk("b_sum_y",     sum_y_b,     7);
    @(negedge clk);
    out_ready_b = 1'b0;
    chk("b_no_extra", out_valid_b, 0);
    chk("b_done_low", done_b,      0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/knns_drain_seq.md
# knns_drain_seq

Result-drain controller sitting directly downstream of the sequential K-nearest-neighbour search stage. It sequences one search (clearing the search stage, counting the N dataset points fed to it), snapshots the final sorted K-entry list, and streams the entries nearest-first over a valid/ready handshake. While streaming it accumulates per-coordinate sums for a downstream centroid step.

## Interface
- W, 32, coordinate width in bits (matches search stage)
- K, 10, number of nearest entries in the search-stage list
- N, 64, dataset points per search; N >= 1
- SW (derived, not overridable) = W + clog2(K+1), sum width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a search; honoured only in IDLE
- pt_valid  in  1  a dataset point is presented to the search stage this cycle
- knn_list  in  2*W*K  search-stage list; entry i = bits [2*W*(i+1)-1 : 2*W*i], {x[W-1:0], y[W-1:0]}, entry 0 nearest
- knn_clr  out  1  one-cycle clear pulse, ORed into the search-stage reset by the top level
- busy  out  1  high in every state except IDLE
- out_valid  out  1  out_x/out_y/out_idx hold a valid entry
- out_ready  in  1  consumer accepts entry when out_valid && out_ready
- out_x  out  W  x of current entry
- out_y  out  W  y of current entry
- out_idx  out  clog2(K)  rank of current entry, 0 = nearest
- sum_x  out  SW  sum of x over accepted entries
- sum_y  out  SW  sum of y over accepted entries
- done  out  1  one-cycle pulse when the last entry is accepted

## Operation
- States: IDLE, CLEAR, SCAN, CAPTURE, DRAIN.
- IDLE: start -> CLEAR; sum_x/sum_y hold previous result.
- CLEAR (1 cycle): knn_clr=1, point counter <= 0, sum_x/sum_y <= 0 -> SCAN.
- SCAN: each pt_valid increments counter; on the pt_valid that makes count == N -> CAPTURE. pt_valid outside SCAN ignored.
- CAPTURE (1 cycle): snapshot knn_list into internal register; entry count M = min(N, K); rank <= 0 -> DRAIN.
- DRAIN: present snapshot entry[rank]; on handshake add x to sum_x, y to sum_y (zero-extended, no overflow possible at SW); if rank == M-1 -> pulse done, -> IDLE; else rank+1.
- N < K: slots M..K-1 (reset-value zero entries of the search stage) never emitted.
- start while busy: ignored. out_ready while out_valid low: ignored.
- knn_list changes after CAPTURE do not affect drained data.

## Timing
- Reset: state IDLE, knn_clr=0, busy=0, out_valid=0, out_x=0, out_y=0, out_idx=0, sum_x=0, sum_y=0, done=0, counter/rank/snapshot 0.
- All outputs registered or decoded from registered state; no combinational path out_ready -> out_valid.
- start at edge t -> CLEAR during cycle t+1 (knn_clr high exactly that cycle) -> SCAN from t+2.
- The search stage updates its list on the same edge that samples the N-th pt_valid; CAPTURE occupies the following cycle, so the snapshot contains all N points.
- First out_valid the cycle after CAPTURE; with out_ready held high, one entry per cycle, M cycles of out_valid, done coincident with the final accepting edge's following cycle (registered, one cycle wide), busy drops the same cycle done rises.
- sum_x/sum_y update the cycle after each handshake; final value stable when done is high and held until next CLEAR.
- Back-pressure: out_valid, out_x, out_y, out_idx stable while out_ready low.
- rst mid-operation: immediate return to reset values; knn_clr not pulsed by reset (top level resets both).

## Test plan
- W=8,K=4,N=6, query (0,0), points (5,5),(1,0),(3,3),(0,2),(9,9),(2,2), pt_valid continuous, out_ready=1 -> knn_clr one pulse; entries idx0..3 = (1,0),(0,2),(2,2),(3,3); sum_x=6, sum_y=7; done one cycle after 4th handshake.
- Same stimulus, out_ready toggled 1,0,0,1,... -> identical entry sequence and sums; outputs frozen on stalled cycles.
- K=4,N=2, points (4,1),(2,6) -> exactly 2 entries emitted ((4,1) idx0 if nearer), sum_x=6, sum_y=7, no zero entries emitted.
- pt_valid gaps (every 3rd cycle) and start pulsed during SCAN/DRAIN -> no effect on count or sequence; CAPTURE only after 6th pt_valid.
- rst asserted mid-DRAIN after 2 handshakes -> all outputs to reset values at once; following start runs a full clean search.
- Back-to-back: start in the cycle busy falls -> new search, sums cleared in CLEAR, prior sums visible until then.
